// File: rtl/adder_link_host_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_link_host_if
// Description : Request/response bundle between local logic and the
//               adder_link_host UART initiator.
//               master : local logic (drives request, reads status)
//               slave  : adder_link_host (reads request, drives status)
//   i_Start      request strobe, sampled only while the host is idle
//   i_A, i_B     4-bit operands captured on an accepted request
//   o_Busy       transaction in flight
//   o_Done       one-cycle completion pulse
//   o_Result     received response byte
//   o_Timeout    no response start bit arrived in time
//   o_Frame_Err  response stop bit sampled low
//   o_Mismatch   response differs from the locally computed sum
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_link_host_if;
    logic       i_Start;
    logic [3:0] i_A;
    logic [3:0] i_B;
    logic       o_Busy;
    logic       o_Done;
    logic [7:0] o_Result;
    logic       o_Timeout;
    logic       o_Frame_Err;
    logic       o_Mismatch;

    modport master (
        output i_Start, i_A, i_B,
        input  o_Busy, o_Done, o_Result, o_Timeout, o_Frame_Err, o_Mismatch
    );

    modport slave (
        input  i_Start, i_A, i_B,
        output o_Busy, o_Done, o_Result, o_Timeout, o_Frame_Err, o_Mismatch
    );
endinterface
`default_nettype wire

// File: rtl/adder_link_host.sv
`default_nettype none
// ============================================================================
// Module      : adder_link_host
// Description : Initiator end of the UART nibble-adder link. Sends {A,B} as
//               one 8N1 byte (LSB first) on tx, then receives the single
//               response byte on rx and reports it together with timeout,
//               framing and mismatch status.
// Ports       : clk, rst (sync, active high)
//               bus  - adder_link_host_if.slave request/status bundle
//               tx   - serial out, idles high
//               rx   - serial in, asynchronous, idles high
// Build option: ADDER_LINK_HOST_CHECK_EN - when defined, the expected-sum
//               register and comparator are built and drive o_Mismatch;
//               otherwise o_Mismatch is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_link_host #(
    parameter int CLKS_PER_BIT = 438,
    parameter int RESP_TIMEOUT = 8760,
    parameter int CNT_WIDTH    = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    adder_link_host_if.slave  bus,
    output logic              tx,
    input  wire logic         rx
);

    localparam logic [CNT_WIDTH-1:0] c_bit_last  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] c_half_last = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] c_tmo_last  = CNT_WIDTH'(RESP_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_TX_START  = 4'd1,
        S_TX_DATA   = 4'd2,
        S_TX_STOP   = 4'd3,
        S_WAIT_RESP = 4'd4,
        S_RX_START  = 4'd5,
        S_RX_DATA   = 4'd6,
        S_RX_STOP   = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt,       w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_tmo,       w_tmo_nxt;
    logic [2:0]           r_bit,       w_bit_nxt;
    logic [7:0]           r_tx_shift,  w_tx_shift_nxt;
    logic [7:0]           r_rx_shift,  w_rx_shift_nxt;
    logic [7:0]           r_result,    w_result_nxt;
    logic                 r_timeout,   w_timeout_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_tx,        w_tx_nxt;
    logic                 r_rx_meta;
    logic                 r_rx_s;
`ifdef ADDER_LINK_HOST_CHECK_EN
    logic [4:0]           r_expected,  w_expected_nxt;
    logic                 r_mismatch,  w_mismatch_nxt;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_bit       <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx        <= 1'b1;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
`ifdef ADDER_LINK_HOST_CHECK_EN
            r_expected  <= '0;
            r_mismatch  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tmo       <= w_tmo_nxt;
            r_bit       <= w_bit_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_result    <= w_result_nxt;
            r_timeout   <= w_timeout_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_tx        <= w_tx_nxt;
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
`ifdef ADDER_LINK_HOST_CHECK_EN
            r_expected  <= w_expected_nxt;
            r_mismatch  <= w_mismatch_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tmo_nxt       = r_tmo;
        w_bit_nxt       = r_bit;
        w_tx_shift_nxt  = r_tx_shift;
        w_rx_shift_nxt  = r_rx_shift;
        w_result_nxt    = r_result;
        w_timeout_nxt   = r_timeout;
        w_frame_err_nxt = r_frame_err;
`ifdef ADDER_LINK_HOST_CHECK_EN
        w_expected_nxt  = r_expected;
        w_mismatch_nxt  = r_mismatch;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.i_Start) begin
                    w_state_nxt     = S_TX_START;
                    w_tx_shift_nxt  = {bus.i_A, bus.i_B};
                    w_result_nxt    = '0;
                    w_timeout_nxt   = 1'b0;
                    w_frame_err_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_tmo_nxt       = '0;
                    w_bit_nxt       = '0;
`ifdef ADDER_LINK_HOST_CHECK_EN
                    w_expected_nxt  = {1'b0, bus.i_A} + {1'b0, bus.i_B};
                    w_mismatch_nxt  = 1'b0;
`endif
                end
            end

            S_TX_START: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_TX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_TX_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt      = '0;
                    // Shift right so the bit on the wire is always bit 0.
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_TX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_TX_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_WAIT_RESP: begin
                // Start bit wins over a coincident timeout terminal count.
                if (!r_rx_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RX_START;
                end else if (r_tmo == c_tmo_last) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_tmo_nxt = r_tmo + c_one;
                end
            end

            S_RX_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_RX_DATA;
                    end else begin
                        // Glitch: resume waiting, timeout budget keeps running.
                        w_state_nxt = S_WAIT_RESP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_RX_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt      = '0;
                    w_rx_shift_nxt = {r_rx_s, r_rx_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_RX_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt       = '0;
                    w_result_nxt    = r_rx_shift;
                    w_frame_err_nxt = ~r_rx_s;
`ifdef ADDER_LINK_HOST_CHECK_EN
                    // Only a cleanly framed byte can be judged a mismatch.
                    w_mismatch_nxt  = r_rx_s && (r_rx_shift != {3'b000, r_expected});
`endif
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // tx is registered from the next state so the line never glitches.
        case (w_state_nxt)
            S_TX_START: w_tx_nxt = 1'b0;
            S_TX_DATA:  w_tx_nxt = w_tx_shift_nxt[0];
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx              = r_tx;
    assign bus.o_Busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.o_Done      = (r_state == S_DONE);
    assign bus.o_Result    = r_result;
    assign bus.o_Timeout   = r_timeout;
    assign bus.o_Frame_Err = r_frame_err;
`ifdef ADDER_LINK_HOST_CHECK_EN
    assign bus.o_Mismatch  = r_mismatch;
`else
    assign bus.o_Mismatch  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_link_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_link_host
// Description : Self-checking bench for adder_link_host. A vector table
//               drives full transactions against a behavioural responder on
//               rx while the tx frame is decoded at bit centres; hand-written
//               sequences cover reset mid-frame, busy requests, rx glitches
//               and the DONE-cycle request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_link_host;

    localparam int c_cpb = 438;
    localparam int c_tmo = 8760;
`ifdef ADDER_LINK_HOST_CHECK_EN
    localparam bit c_chk = 1'b1;
`else
    localparam bit c_chk = 1'b0;
`endif

    localparam int M_NORMAL  = 0;
    localparam int M_SILENT  = 1;
    localparam int M_BADSTOP = 2;
    localparam int M_NOISY   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    adder_link_host_if bus ();

    adder_link_host #(
        .CLKS_PER_BIT (c_cpb),
        .RESP_TIMEOUT (c_tmo),
        .CNT_WIDTH    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .rx  (rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         mode;
        logic [7:0] resp;
        logic [7:0] exp_res;
        logic       exp_to;
        logic       exp_fe;
        logic       exp_mm;   // mismatch expected when checking is built
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder rx level for cycle c after accept. Response start bit is
    // launched 10 cycles after the host stop bit ends (cycle 4380).
    function automatic logic rx_level(input int mode, input logic [7:0] resp, input int c);
        int rs;
        int idx;
        if (mode == M_SILENT) return 1'b1;
        if (mode == M_NOISY && c >= 4400 && c < 4500) return 1'b0;
        rs = (mode == M_NOISY) ? 4700 : 4390;
        if (c < rs) return 1'b1;
        idx = (c - rs) / c_cpb;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return resp[idx-1];
        if (idx == 9) return (mode != M_BADSTOP);
        return 1'b1;
    endfunction

    task automatic run_txn(input vec_t v, input bit restart_test);
        logic [9:0] bits;
        logic [7:0] exp_tx;
        int c_done;
        int c;
        int extra;
        exp_tx = {v.a, v.b};
        bits   = '1;
        c_done = -1;
        bus.i_A     = v.a;
        bus.i_B     = v.b;
        bus.i_Start = 1'b1;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        check("busy_after_accept", 32'(bus.o_Busy), 32'd1);
        check("tx_low_after_accept", 32'(tx), 32'd0);
        for (c = 1; c <= 20000; c++) begin
            @(posedge clk); #1;
            if (c >= c_cpb/2 && (c - c_cpb/2) % c_cpb == 0 && (c - c_cpb/2) / c_cpb <= 9)
                bits[(c - c_cpb/2) / c_cpb] = tx;
            if (c == c_cpb - 1) check("start_bit_last_cycle", 32'(tx), 32'd0);
            if (c == c_cpb)     check("bit0_first_cycle", 32'(tx), 32'(exp_tx[0]));
            if (v.mode == M_NOISY) begin
                if (c == 100) begin
                    bus.i_Start = 1'b1;
                    bus.i_A     = 4'h9;
                    bus.i_B     = 4'h9;
                end
                if (c == 101) bus.i_Start = 1'b0;
            end
            if (bus.o_Done) begin
                c_done = c;
                break;
            end
            rx = rx_level(v.mode, v.resp, c);
        end
        rx = 1'b1;
        check("done_seen", 32'(c_done >= 0), 32'd1);
        if (c_done >= 0) begin
            check("tx_start_bit", 32'(bits[0]), 32'd0);
            check("tx_byte", 32'(bits[8:1]), 32'(exp_tx));
            check("tx_stop_bit", 32'(bits[9]), 32'd1);
            check("result", 32'(bus.o_Result), 32'(v.exp_res));
            check("timeout_flag", 32'(bus.o_Timeout), 32'(v.exp_to));
            check("frame_err_flag", 32'(bus.o_Frame_Err), 32'(v.exp_fe));
            check("mismatch_flag", 32'(bus.o_Mismatch), 32'(c_chk & v.exp_mm));
            check("busy_low_at_done", 32'(bus.o_Busy), 32'd0);
            if (v.mode == M_SILENT)
                check("timeout_latency", 32'(c_done), 32'(10*c_cpb + c_tmo));
        end
        if (restart_test) begin
            // Request present during the DONE cycle must be ignored.
            bus.i_Start = 1'b1;
            @(posedge clk); #1;
            check("start_in_done_ignored", 32'(bus.o_Busy), 32'd0);
            @(posedge clk); #1;
            check("reaccept_next_cycle", 32'(bus.o_Busy), 32'd1);
            bus.i_Start = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("busy_cleared_by_reset", 32'(bus.o_Busy), 32'd0);
            check("tx_high_after_reset", 32'(tx), 32'd1);
        end else begin
            extra = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (bus.o_Done) extra++;
            end
            check("single_done_pulse", 32'(extra), 32'd0);
        end
    endtask

    vec_t vecs [5];
    vec_t v;

    initial begin
        bus.i_Start = 1'b0;
        bus.i_A     = 4'h0;
        bus.i_B     = 4'h0;

        //           a     b     mode       resp   exp_res to    fe    mm
        vecs[0] = '{4'h3, 4'h4, M_NORMAL,  8'h07, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'hF, 4'hF, M_NORMAL,  8'h0E, 8'h0E, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4'hF, 4'hF, M_NORMAL,  8'h1E, 8'h1E, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'h1, 4'h2, M_SILENT,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'h1, 4'h2, M_BADSTOP, 8'h03, 8'h03, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(bus.o_Busy), 32'd0);
        check("reset_done", 32'(bus.o_Done), 32'd0);
        check("reset_result", 32'(bus.o_Result), 32'd0);
        check("reset_flags", 32'({bus.o_Timeout, bus.o_Frame_Err, bus.o_Mismatch}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i], 1'b0);

        // Reset in the middle of data bit 3 of {5,6} = 0x56 (bit 3 = 0).
        bus.i_A     = 4'h5;
        bus.i_B     = 4'h6;
        bus.i_Start = 1'b1;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        repeat (1900) @(posedge clk);
        #1;
        check("tx_data_bit3", 32'(tx), 32'd0);
        check("busy_mid_frame", 32'(bus.o_Busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("tx_high_after_mid_reset", 32'(tx), 32'd1);
        check("busy_low_after_mid_reset", 32'(bus.o_Busy), 32'd0);
        v = '{4'h2, 4'h2, M_NORMAL, 8'h04, 8'h04, 1'b0, 1'b0, 1'b0};
        run_txn(v, 1'b0);

        // Busy-time request plus an rx glitch during the response wait.
        v = '{4'h3, 4'h5, M_NOISY, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0};
        run_txn(v, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_link_host.md
Name: adder_link_host

Overview:
- Initiator end of the UART nibble-adder link. Packs two 4-bit operands into one byte {A,B} and transmits it on tx (8N1, LSB first).
- Then waits for the single response byte on rx and checks it against the locally computed {3'b000, A+B}.
- Reports the result, or a timeout/framing/mismatch status, to local logic.
- Used on the host FPGA/test fixture that drives the adder responder over a two-wire serial link.

Parameters:
- CLKS_PER_BIT, 438, clocks per UART bit (matches the responder's 437 terminal count, counted 0..437).
- RESP_TIMEOUT, 8760, clocks allowed from end of TX stop bit to detected RX start bit (20 bit times).
- CNT_WIDTH, 32, width of the bit and timeout counters.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- i_Start  in  1  request; sampled only in IDLE.
- i_A  in  4  operand A, captured on accepted i_Start.
- i_B  in  4  operand B, captured on accepted i_Start.
- o_Busy  out  1  high from the cycle after accept until the cycle o_Done pulses.
- o_Done  out  1  one-cycle completion pulse.
- o_Result  out  8  received byte; valid when o_Done is high, held until next accept.
- o_Timeout  out  1  status valid with o_Done: no response within RESP_TIMEOUT.
- o_Frame_Err  out  1  status valid with o_Done: response stop bit sampled low.
- o_Mismatch  out  1  status valid with o_Done: o_Result != {3'b000, A+B}.
- tx  out  1  serial out; idles high.
- rx  in  1  serial in; asynchronous, idles high.

Behaviour:
- Reset is synchronous and active-high. On rst, all of the following hold on the next edge:
  - State = IDLE.
  - tx = 1.
  - o_Busy, o_Done, o_Timeout, o_Frame_Err, o_Mismatch = 0.
  - o_Result = 0x00.
  - All counters = 0.
  - rx synchroniser flops = 1.
- Reset mid-operation abandons the frame. tx returns high on the next cycle; a partially sent frame is not completed.
- rx passes through a 2-flop synchroniser before any use (rx_s).
- States: IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RESP, RX_START, RX_DATA, RX_STOP, DONE.
- IDLE:
  - tx=1.
  - On i_Start=1: capture {i_A,i_B} into the shift byte, latch A+B (5-bit) into the expected value, clear status flags, go to TX_START, set o_Busy.
  - i_Start while not in IDLE is ignored (no queueing).
- TX_START: tx=0 for CLKS_PER_BIT cycles. tx first goes low the cycle after accept.
- TX_DATA: bits 0..7 of {A,B}, LSB first, CLKS_PER_BIT cycles each.
- TX_STOP: tx=1 for CLKS_PER_BIT cycles, then go to WAIT_RESP with the timeout counter at 0.
- WAIT_RESP:
  - rx_s==0 -> RX_START.
  - Counter reaches RESP_TIMEOUT-1 with no start bit -> set o_Timeout, go to DONE.
  - A start bit detected on the same cycle as the timeout terminal count takes priority, so no timeout is flagged.
- RX_START: wait to count CLKS_PER_BIT/2 (integer divide), then re-sample.
  - Still 0 -> RX_DATA.
  - High (glitch) -> back to WAIT_RESP. The timeout counter is not reset.
- RX_DATA: sample rx_s every CLKS_PER_BIT cycles at bit centre, LSB first, 8 bits.
- RX_STOP: sample after CLKS_PER_BIT cycles.
  - 0 -> set o_Frame_Err.
  - The byte is kept either way; go to DONE.
- DONE:
  - o_Done=1 for exactly one cycle; o_Busy drops in the same cycle.
  - o_Result holds the received byte (0x00 on timeout).
  - o_Mismatch is set only if no timeout and no framing error occurred and the byte differs from the expected value.
  - Then go to IDLE.
- i_Start sampled in the DONE cycle is ignored. Earliest re-accept is the following cycle.
- Frame latency: 10*CLKS_PER_BIT from accept to end of stop bit.
- Sum width: A+B is computed at 5 bits (max 15+15=30=0x1E), zero-extended to 8 bits. No wrap.

Optional Feature:
- Macro: ADDER_LINK_HOST_CHECK_EN.
- Defined: the expected-value register and comparator are built; o_Mismatch behaves as above.
- Undefined: neither is built, o_Mismatch is tied to 0, and all other behaviour is unchanged.

Test Plan:
- A=3, B=4, i_Start pulse; bench responder returns 0x07 -> tx carries 0x34 LSB-first, each bit 438 clocks; o_Done pulse with o_Result=0x07, all flags 0.
- A=0xF, B=0xF; bench returns 0x0E -> o_Result=0x0E, o_Mismatch=1 with CHECK_EN defined, 0 without.
- A=1, B=2; bench never drives rx -> o_Done exactly 8760 clocks after stop-bit end; o_Timeout=1, o_Result=0x00.
- Bench returns 0x03 with stop bit forced 0 -> o_Frame_Err=1, o_Result=0x03, o_Mismatch=0.
- Assert rst during TX_DATA bit 3 -> tx=1 and o_Busy=0 next cycle; new request A=2, B=2 then completes normally with 0x04.
- Pulse i_Start while busy, plus a 100-clock low glitch on rx in WAIT_RESP -> second request ignored, glitch rejected, single o_Done for the original transaction.
